video_timing_gen: RTL

Upstream source for the video pipeline. Generates 1080p60 CEA-861 raster timing: blanking, HDMI {D_sync, Vsync, Hsync}, active pixel coordinates and a start-of-frame pulse. It also generates an optional built-in test pattern. Its vh_blank_o, dvh_sync_o and vid_rgb_o connect directly to the processing stage's vh_blank_i, dvh_sync_i and vid_rgb_i, clocked by the same clk_i/cen_i.

---
 rtl/video_pkg.sv | 49 ++++
 rtl/video_tim_axis.sv | 55 +++++
 rtl/video_timing_gen.sv | 130 +++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types and constants for the raster timing generator
package video_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } axis_state_t;

  localparam int H_ACTIVE_1080P = 1920;
  localparam int H_FRONT_1080P  = 88;
  localparam int H_SYNC_1080P   = 44;
  localparam int H_BACK_1080P   = 148;
  localparam int V_ACTIVE_1080P = 1080;
  localparam int V_FRONT_1080P  = 4;
  localparam int V_SYNC_1080P   = 5;
  localparam int V_BACK_1080P   = 36;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;
  localparam logic [23:0] RGB_GRID_BG = 24'h000040;

  localparam int DVH_DE = 2;
  localparam int DVH_VS = 1;
  localparam int DVH_HS = 0;
  localparam int VHB_V  = 1;
  localparam int VHB_H  = 0;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_tim_axis.sv
// rtl/video_tim_axis.sv - one timing axis: ACTIVE/FRONT/SYNC/BACK walker with in-state counter
module video_tim_axis
  import video_pkg::*;
#(
  parameter int ACTIVE = 1920,
  parameter int FRONT  = 88,
  parameter int SYNC   = 44,
  parameter int BACK   = 148,
  parameter int W      = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        step_i,
  output axis_state_t state_o,
  output logic [W-1:0] pos_o,
  output logic        last_o
);

  axis_state_t  state_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] len_m1;

  always_comb begin
    case (state_q)
      ST_ACTIVE: len_m1 = W'(ACTIVE - 1);
      ST_FRONT:  len_m1 = W'(FRONT - 1);
      ST_SYNC:   len_m1 = W'(SYNC - 1);
      default:   len_m1 = W'(BACK - 1);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ACTIVE;
      cnt_q   <= '0;
    end else if (step_i) begin
      if (cnt_q == len_m1) begin
        cnt_q <= '0;
        case (state_q)
          ST_ACTIVE: state_q <= ST_FRONT;
          ST_FRONT:  state_q <= ST_SYNC;
          ST_SYNC:   state_q <= ST_BACK;
          default:   state_q <= ST_ACTIVE;
        endcase
      end else begin
        cnt_q <= cnt_q + W'(1);
      end
    end
  end

  assign state_o = state_q;
  assign pos_o   = cnt_q;
  assign last_o  = (state_q == ST_BACK) && (cnt_q == len_m1);

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - CEA-861 raster timing, sync encoding and built-in test pattern
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_1080P,
  parameter int H_FRONT  = H_FRONT_1080P,
  parameter int H_SYNC   = H_SYNC_1080P,
  parameter int H_BACK   = H_BACK_1080P,
  parameter int V_ACTIVE = V_ACTIVE_1080P,
  parameter int V_FRONT  = V_FRONT_1080P,
  parameter int V_SYNC   = V_SYNC_1080P,
  parameter int V_BACK   = V_BACK_1080P,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic [1:0]  pattern_sel_i,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output logic [11:0] h_pos_o,
  output logic [10:0] v_pos_o,
  output logic        sof_o,
  output logic [23:0] vid_rgb_o
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam bit PARAMS_OK = (H_ACTIVE >= 1) && (H_FRONT >= 1) && (H_SYNC >= 1) && (H_BACK >= 1) &&
                             (V_ACTIVE >= 1) && (V_FRONT >= 1) && (V_SYNC >= 1) && (V_BACK >= 1) &&
                             (H_ACTIVE % 8 == 0);

  axis_state_t h_state, v_state;
  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_last, v_last;

  logic        h_act, v_act, de;
  logic [11:0] h_pix;
  logic [10:0] v_pix;
  logic [2:0]  bar_idx;
  logic [23:0] rgb_d;

  logic [1:0]  vh_blank_q;
  logic [2:0]  dvh_sync_q;
  logic [11:0] h_pos_q;
  logic [10:0] v_pos_q;
  logic        sof_q;
  logic [23:0] rgb_q;
  logic        first_pix_q;

  video_tim_axis #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(12)
  ) u_h_axis (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .step_i (cen_i),
    .state_o(h_state),
    .pos_o  (h_cnt),
    .last_o (h_last)
  );

  video_tim_axis #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(11)
  ) u_v_axis (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .step_i (cen_i & h_last),
    .state_o(v_state),
    .pos_o  (v_cnt),
    .last_o (v_last)
  );

  always_comb begin
    h_act = (h_state == ST_ACTIVE);
    v_act = (v_state == ST_ACTIVE);
    de    = h_act & v_act;
    h_pix = h_act ? h_cnt : '0;
    v_pix = v_act ? v_cnt : v_pos_q;
    // bar index by threshold compares against constant bar edges
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(h_pix) >= k * BAR_W) bar_idx = bar_idx + 3'd1;
    end
    rgb_d = RGB_BLACK;
    if (de) begin
      case (pattern_sel_i)
        2'd0:    rgb_d = bar_colour(bar_idx);
        2'd1:    rgb_d = (h_pix[5:0] == 6'd0 || v_pix[5:0] == 6'd0) ? RGB_WHITE : RGB_GRID_BG;
        2'd2:    rgb_d = {3{h_pix[10:3]}};
        default: rgb_d = RGB_BLACK;
      endcase
    end
  end

  // first_pix_q marks that the axis FSMs currently sit on pixel (0,0)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vh_blank_q  <= 2'b11;
      dvh_sync_q  <= {1'b0, ~SYNC_POL, ~SYNC_POL};
      h_pos_q     <= '0;
      v_pos_q     <= '0;
      sof_q       <= 1'b0;
      rgb_q       <= '0;
      first_pix_q <= 1'b1;
    end else if (cen_i) begin
      vh_blank_q[VHB_V]  <= ~v_act;
      vh_blank_q[VHB_H]  <= ~h_act;
      dvh_sync_q[DVH_DE] <= de;
      dvh_sync_q[DVH_VS] <= (v_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      dvh_sync_q[DVH_HS] <= (h_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      h_pos_q            <= h_pix;
      v_pos_q            <= v_pix;
      sof_q              <= first_pix_q;
      rgb_q              <= rgb_d;
      first_pix_q        <= h_last & v_last;
    end
  end

  always_ff @(posedge clk_i) begin
    assert (PARAMS_OK);
  end

  assign vh_blank_o = vh_blank_q;
  assign dvh_sync_o = dvh_sync_q;
  assign h_pos_o    = h_pos_q;
  assign v_pos_o    = v_pos_q;
  assign sof_o      = sof_q;
  assign vid_rgb_o  = rgb_q;

endmodule
